// File: rtl/lcv_div_pkg.sv
// Shared types and helpers for the lcv_div_multi_cycle sequential divider.
// WIDTH is supported up to MAX_WIDTH bits.
package lcv_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam int MAX_WIDTH = 64;

    // Most-negative two's-complement value for a w-bit word, zero-extended to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] most_neg(input int w);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/lcv_div_step.sv
// One restoring-division iteration: shift {rem,quot} left and trial-subtract the divisor.
// Relies on rem < divisor on entry, so a clear bit WIDTH in the trial means no borrow.
module lcv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);

    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;
    logic           w_borrow;

    assign w_rem_sh = {i_rem, i_quot[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, i_divisor};
    assign w_borrow = w_trial[WIDTH];

    assign o_rem  = w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quot = {i_quot[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/lcv_div_multi_cycle.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) with valid/ready on both sides.
// Optional macro LCV_DIV_FAST_SPECIAL_EN: divide-by-zero and overflow skip the iteration phase.
//
// state | meaning
// IDLE  | ready for a request, inp_ready=1
// CALC  | one restoring quotient bit per cycle, WIDTH cycles
// FIX   | sign correction and special-case overrides, results registered
// DONE  | result presented until outp_ready
module lcv_div_multi_cycle
    import lcv_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_valid,
    output logic             inp_ready,
    input  logic             inp_signed,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    output logic             outp_valid,
    input  logic             outp_ready,
    output logic [WIDTH-1:0] outp_quot,
    output logic [WIDTH-1:0] outp_rem,
    output logic             outp_div_by_zero
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_dbz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_outp_quot;
    logic [WIDTH-1:0] r_outp_rem;
    logic             r_outp_valid;
    logic             r_outp_dbz;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_dbz;
    logic             w_ovf;
    logic             w_skip_calc;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quot;
    logic [WIDTH-1:0] w_fix_quot;
    logic [WIDTH-1:0] w_fix_rem;

    assign inp_ready        = (r_state == ST_IDLE);
    assign w_accept         = inp_valid && inp_ready;
    assign w_a_neg          = inp_signed && inp_a[WIDTH-1];
    assign w_b_neg          = inp_signed && inp_b[WIDTH-1];
    assign w_a_mag          = w_a_neg ? -inp_a : inp_a;
    assign w_b_mag          = w_b_neg ? -inp_b : inp_b;
    assign w_dbz            = (inp_b == '0);
    assign w_ovf            = inp_signed && (inp_a == MOST_NEG) && (inp_b == '1);

    assign outp_valid       = r_outp_valid;
    assign outp_quot        = r_outp_quot;
    assign outp_rem         = r_outp_rem;
    assign outp_div_by_zero = r_outp_dbz;

`ifdef LCV_DIV_FAST_SPECIAL_EN
    assign w_skip_calc = w_dbz || w_ovf;
`else
    assign w_skip_calc = 1'b0;
`endif

    lcv_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_quot    (w_step_quot)
    );

    // Overrides win over the iterated result, which is meaningless for these cases.
    always_comb begin
        w_fix_quot = r_qneg ? -r_quot : r_quot;
        w_fix_rem  = r_rneg ? -r_rem : r_rem;
        if (r_dbz) begin
            w_fix_quot = '1;
            w_fix_rem  = r_a;
        end else if (r_ovf) begin
            w_fix_quot = MOST_NEG;
            w_fix_rem  = '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_skip_calc ? ST_FIX : ST_CALC;
            ST_CALC: if (r_cnt == '0) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: if (outp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_div        <= '0;
            r_a          <= '0;
            r_qneg       <= 1'b0;
            r_rneg       <= 1'b0;
            r_dbz        <= 1'b0;
            r_ovf        <= 1'b0;
            r_outp_quot  <= '0;
            r_outp_rem   <= '0;
            r_outp_valid <= 1'b0;
            r_outp_dbz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rem  <= '0;
                        r_quot <= w_a_mag;
                        r_div  <= w_b_mag;
                        r_a    <= inp_a;
                        r_qneg <= w_a_neg ^ w_b_neg;
                        r_rneg <= w_a_neg;
                        r_dbz  <= w_dbz;
                        r_ovf  <= w_ovf;
                        r_cnt  <= CW'(WIDTH - 1);
                    end
                end
                ST_CALC: begin
                    r_rem  <= w_step_rem;
                    r_quot <= w_step_quot;
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                ST_FIX: begin
                    r_outp_quot  <= w_fix_quot;
                    r_outp_rem   <= w_fix_rem;
                    r_outp_dbz   <= r_dbz;
                    r_outp_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (outp_ready) r_outp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcv_div_multi_cycle.sv
// Scoreboard bench for lcv_div_multi_cycle (WIDTH=32): driver queues expectations,
// negedge monitor checks each result handshake including inclusive accept-to-valid latency.
module tb_lcv_div_multi_cycle;

    localparam int W = 32;
`ifdef LCV_DIV_FAST_SPECIAL_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = W + 2;
`endif
    localparam int LAT_NORM = W + 2;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inp_valid;
    logic         inp_ready;
    logic         inp_signed;
    logic [W-1:0] inp_a;
    logic [W-1:0] inp_b;
    logic         outp_valid;
    logic         outp_ready;
    logic [W-1:0] outp_quot;
    logic [W-1:0] outp_rem;
    logic         outp_div_by_zero;

    exp_t exp_q[$];
    int   acc_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic rand_rdy = 1'b0;

    lcv_div_multi_cycle #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .inp_valid        (inp_valid),
        .inp_ready        (inp_ready),
        .inp_signed       (inp_signed),
        .inp_a            (inp_a),
        .inp_b            (inp_b),
        .outp_valid       (outp_valid),
        .outp_ready       (outp_ready),
        .outp_quot        (outp_quot),
        .outp_rem         (outp_rem),
        .outp_div_by_zero (outp_div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dbz = 1'b0;
        e.lat = LAT_NORM;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = LAT_SP;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = '0; e.lat = LAT_SP;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: records accepts, checks every result handshake against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (inp_valid && inp_ready) acc_q.push_back(cyc + 1);
            if (outp_valid && !prev_valid) begin
                rise_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stale_result actual=valid_with_nothing_pending required=no_valid");
                end
            end
            if (outp_valid && outp_ready && exp_q.size() > 0 && acc_q.size() > 0) begin
                exp_t e;
                int   a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("quot", outp_quot, e.q);
                chk("rem", outp_rem, e.r);
                chk("div_by_zero", W'(outp_div_by_zero), W'(e.dbz));
                chk("latency", W'(rise_cyc - a + 1), W'(e.lat));
            end
            prev_valid = outp_valid;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) outp_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int n;
        exp_q.push_back(e);
        @(posedge clk); #1;
        inp_signed = s; inp_a = a; inp_b = b; inp_valid = 1'b1;
        n = 0;
        while (!inp_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inp_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
            void'(exp_q.pop_back());
            inp_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            inp_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic d, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dbz = d; e.lat = lat;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_valid;
        int   n;
        rst = 1'b0; inp_valid = 1'b0; inp_signed = 1'b0; inp_a = '0; inp_b = '0; outp_ready = 1'b1;
        #12;
        chk("rst_valid", W'(outp_valid), '0);
        chk("rst_quot", outp_quot, '0);
        chk("rst_rem", outp_rem, '0);
        chk("rst_dbz", W'(outp_div_by_zero), '0);
        @(posedge clk); #1; rst = 1'b1;
        chk("rst_inp_ready", W'(inp_ready), 32'd1);

        // Directed, hand-computed
        issue(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, LAT_NORM));
        drain();
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_NORM));
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 32'd1, 1'b0, LAT_NORM));
        issue(1'b0, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 32'd5, 1'b1, LAT_SP));
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0, LAT_SP));
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0, LAT_NORM));
        issue(1'b0, 32'd3, 32'd10, mk(32'd0, 32'd3, 1'b0, LAT_NORM));
        issue(1'b1, 32'hFFFF_FFF6, 32'd0, mk(32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b1, LAT_SP));
        drain();

        // Backpressure: 1000/33 = 30 r 10
        outp_ready = 1'b0;
        issue(1'b0, 32'd1000, 32'd33, mk(32'd30, 32'd10, 1'b0, LAT_NORM));
        n = 0;
        while (!outp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", W'(outp_valid), 32'd1);
            chk("bp_quot", outp_quot, 32'd30);
            chk("bp_rem", outp_rem, 32'd10);
            chk("bp_inp_ready", W'(inp_ready), '0);
        end
        outp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after", W'(inp_ready), 32'd1);
        chk("bp_valid_after", W'(outp_valid), '0);
        drain();

        // Reset at iteration 10 of CALC
        issue(1'b0, 32'd12345, 32'd17, mk(32'd726, 32'd3, 1'b0, LAT_NORM));
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", W'(outp_valid), '0);
        chk("midrst_inp_ready", W'(inp_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        chk("postrst_inp_ready", W'(inp_ready), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (outp_valid) saw_valid = 1'b1;
        end
        chk("postrst_no_stale", W'(saw_valid), '0);
        issue(1'b0, 32'd12345, 32'd17, mk(32'd726, 32'd3, 1'b0, LAT_NORM));
        drain();

        // Back-to-back with random valid gaps and random outp_ready
        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic         s;
            logic [W-1:0] a;
            logic [W-1:0] b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = ~W'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            if (i == 5) begin s = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            issue(s, a, b, model(s, a, b));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        rand_rdy = 1'b0;
        outp_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcv_div_multi_cycle.md
Name: lcv_div_multi_cycle

Overview:
Sequential restoring divider, the inverse companion to the team's multiply-accumulate units. Accepts one dividend/divisor pair over a valid/ready handshake and iterates one quotient bit per cycle. Presents quotient and remainder over a second valid/ready handshake. Used by the CPU execute stage for DIV/DIVU/REM/REMU, where a single-cycle DSP divide is not available.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits (must be at least 2)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
inp_valid  input  1  request valid
inp_ready  output  1  divider can accept a request
inp_signed  input  1  1 = two's-complement operands, 0 = unsigned
inp_a  input  WIDTH  dividend
inp_b  input  WIDTH  divisor
outp_valid  output  1  result valid
outp_ready  input  1  consumer accepts result
outp_quot  output  WIDTH  quotient
outp_rem  output  WIDTH  remainder
outp_div_by_zero  output  1  inp_b was zero for this result

Behaviour:
- Reset (rst low, asynchronous): state IDLE; outp_valid=0; outp_quot=0; outp_rem=0; outp_div_by_zero=0; all internal registers cleared. inp_ready=1 in the first cycle after rst deasserts.
- States: IDLE, CALC, FIX, DONE.
- IDLE: inp_ready=1. Request is accepted when inp_valid&&inp_ready.
  - On accept, latch the magnitudes |a| and |b| (absolute values only when inp_signed=1), the quotient sign (sign(a)^sign(b)), the remainder sign (sign(a)), and the div-by-zero and overflow flags.
  - Overflow: inp_signed=1, inp_a = most-negative value, inp_b = all-ones.
  - Load iteration counter = WIDTH-1 and go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem,quot} left by 1.
  - Trial subtract: rem_trial = rem - divisor, computed WIDTH+1 bits wide.
  - If no borrow: commit rem_trial and set quot LSB to 1. Otherwise set quot LSB to 0.
  - Exactly WIDTH cycles; when counter==0, go to FIX.
- FIX: one cycle.
  - Negate quotient if the quotient sign is set; negate remainder if the remainder sign is set (signed mode only).
  - Divide by zero overrides: quot = all-ones, rem = original inp_a.
  - Overflow overrides: quot = most-negative value, rem = 0.
  - Register the results onto the output ports, set outp_valid=1, go to DONE.
- DONE: outputs held stable while outp_valid && !outp_ready. On outp_ready: outp_valid=0, go to IDLE. inp_ready=0 in DONE.
- Latency: outp_valid rises WIDTH+2 clock edges after the accepting edge. Throughput is one request per WIDTH+3 cycles minimum.
- inp_ready is 0 in CALC, FIX and DONE. Inputs are ignored there; the upstream stage holds inp_valid.
- Invariant: unsigned mode gives a = q*b + r with r < b. Signed mode gives the remainder the sign of the dividend (truncating division).
- Reset mid-operation: in-flight division is abandoned and no result is produced.

Optional Feature:
LCV_DIV_FAST_SPECIAL_EN
- Defined: divide-by-zero and overflow requests skip CALC. IDLE goes to FIX directly, so outp_valid rises 2 edges after acceptance.
- Undefined: these requests take the full WIDTH+2 latency; CALC results are discarded and overridden in FIX.
- Result values are identical in both builds.

Decomposition:
- Package lcv_div_pkg holds:
  - state enum (IDLE, CALC, FIX, DONE);
  - function returning the most-negative constant for a width;
  - counter-width localparam helper, $clog2(WIDTH).
- Sub-module lcv_div_step: purely combinational restoring step. Inputs are rem, quot and divisor; outputs are next rem and next quot. Parameterised by WIDTH.
- The top level holds the FSM, handshakes, sign handling and overrides.

Test Plan:
- Unsigned 100/7, WIDTH=32 -> quot=14, rem=2, div_by_zero=0; outp_valid exactly 34 edges after accept.
- Signed -7/2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7/-2 -> quot=0xFFFFFFFD, rem=1.
- Divide by zero: unsigned 5/0 -> quot=0xFFFFFFFF, rem=5, div_by_zero=1. Latency is 2 with LCV_DIV_FAST_SPECIAL_EN defined, 34 without.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0.
- Backpressure: outp_ready held low 10 cycles after outp_valid -> outputs stable, inp_ready=0. After the outp_ready pulse, inp_ready=1 the next cycle. Back-to-back requests with random valid/ready match the reference model.
- Reset mid-CALC (assert rst at iteration 10) -> outp_valid=0 immediately. After release: inp_ready=1, no stale result ever presented, and the next request is correct.
